buzzer_tone_gen: RTL and testbench
==================================

Name: buzzer_tone_gen

Overview:
Downstream consumer of the note-to-period lookup: takes a 20-bit tone period (clocks per cycle) plus a note duration in ms and drives the passive buzzer pin with a square wave.
- Plays one note per valid/ready handshake, then inserts a fixed silent gap so repeated notes articulate.
- Signals completion so the score sequencer upstream can issue the next note.

Parameters:
- CLK_FRE, 50, system clock in MHz; ms tick = CLK_FRE*1000 clocks.
- GAP_MS, 10, silent gap after every note, in ms; 0 allowed (no gap).
- DUR_W, 16, width of the duration field in ms.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- note_valid  in  1  note request.
- note_ready  out  1  block idle, can accept a note.
- cycle  in  20  tone period in clocks; 0 or 1 = rest (silence).
- dur_ms  in  DUR_W  note length in ms.
- buzzer  out  1  buzzer drive; 1 = off/idle level.
- busy  out  1  note or gap in progress.
- done  out  1  one-clock pulse at the end of note+gap.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, buzzer=1, note_ready=1, busy=0, done=0, all counters 0.
- FSM states:
  - IDLE: note_ready=1. On note_valid&note_ready, latch cycle and dur_ms, clear the period and ms counters, then go to PLAY, or to GAP if dur_ms==0.
  - PLAY: ms counter increments on each ms tick. When it reaches the latched dur_ms, clear the counters and go to GAP, or go straight to DONE if GAP_MS==0.
  - GAP: buzzer=1. After GAP_MS ms ticks, go to DONE.
  - DONE: one cycle. done=1, note_ready=1, busy=0. A note presented in this cycle is accepted exactly as in IDLE (back-to-back notes allowed). The next state is then IDLE.
- busy=1 in PLAY and GAP only. note_ready=0 in PLAY and GAP; note_valid is ignored there.
- Tone generation in PLAY:
  - Period counter pcnt runs 0..cycle_l-1 and wraps to 0.
  - buzzer = 0 while pcnt < (cycle_l>>1), else 1. The first half-period is low, starting the first PLAY cycle.
  - Odd cycle values give a high half one clock longer.
  - cycle_l<2 means rest: buzzer held at 1 for the whole duration.
- ms prescaler counts 0..CLK_FRE*1000-1 and pulses a tick on wrap. It restarts at acceptance and at PLAY→GAP.
- Timing: after the acceptance edge, PLAY lasts exactly dur_ms*CLK_FRE*1000 clocks and GAP lasts exactly GAP_MS*CLK_FRE*1000 clocks. done is asserted in the following cycle.
- Latched values are used for the whole note; input changes after acceptance have no effect.
- ms counter is DUR_W bits wide; dur_ms max = 2^DUR_W-1, with no wrap before the compare.
- Reset asserted mid-note aborts immediately: buzzer=1, no done pulse. After release the block is in IDLE.

Optional Feature:
BUZZER_DUTY_EN.
- Defined: adds input duty_sel[1:0]. The low phase is pcnt < (cycle_l>>(duty_sel+1)), giving 50/25/12.5/6.25 % low-time duty as a volume control. duty_sel is latched at acceptance.
- Undefined: no port, fixed 50 % duty as above.

Decomposition:
- Package buzzer_pkg holds:
  - the state enum (IDLE, PLAY, GAP, DONE);
  - the period width constant 20;
  - a function ms_ticks(clk_fre) returning clk_fre*1000.
- One sub-module, ms_tick_gen (prescaler with synchronous clear input and tick output). Reused by the sequencer upstream.

Test Plan (CLK_FRE=1, GAP_MS=2):
- Reset: hold rst_n=0 → buzzer=1, note_ready=1, busy=0, done=0. Release with note_valid=0 → outputs unchanged.
- Tone note: cycle=100, dur_ms=3.
  - buzzer toggles 50 low/50 high for exactly 3000 clocks (30 periods).
  - Then buzzer=1 for 2000 clocks.
  - done pulses once, 5000 clocks after acceptance.
- Rest: cycle=0, dur_ms=2 → buzzer stays 1 for 4000 clocks, busy=1 throughout, then done pulses.
- Zero duration: dur_ms=0, cycle=100 → no low level on buzzer, done after 2000 clocks.
- Handshake:
  - note_valid held high with changing cycle while busy → note_ready=0, latched period unchanged.
  - Note presented in the DONE cycle → accepted, PLAY starts on the next clock.
- Abort: assert rst_n=0 1500 clocks into PLAY → buzzer=1 immediately, no done pulse. A new note after release plays normally.

Source files
------------

// File: rtl/buzzer_tone_gen_pkg.sv
// buzzer_pkg: shared types and constants for the buzzer tone generator and the
// millisecond prescaler.
//   state_t   : note FSM states (IDLE, PLAY, GAP, DONE)
//   PERIOD_W  : width of the tone period field, in clocks
//   ms_ticks(): clocks per millisecond for a clock given in MHz
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PERIOD_W = 20;

  function automatic int ms_ticks(input int clk_fre);
    return clk_fre * 1000;
  endfunction

endpackage

// File: rtl/buzzer_tone_gen_ms_tick.sv
// ms_tick_gen: millisecond prescaler. Counts 0..ms_ticks(CLK_FRE)-1 while en
// is high and raises tick during the last count of each millisecond.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous restart of the count (wins over en)
//   en    : count enable
//   tick  : high for one clock at the end of each millisecond
module ms_tick_gen
  import buzzer_pkg::*;
#(
  parameter int CLK_FRE = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TICKS = ms_ticks(CLK_FRE);
  localparam int CW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // tick deliberately ignores clr: the FSM uses tick to decide when to clear,
  // so gating it here would close a combinational loop.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: plays one note per valid/ready handshake as a square wave on
// the passive buzzer pin, then holds a silent gap so repeated notes articulate,
// then pulses done for one clock.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   note_valid  : note request
//   note_ready  : high in IDLE and DONE, a note can be accepted
//   cycle       : tone period in clocks, 0 or 1 = rest
//   dur_ms      : note length in ms
//   duty_sel    : (BUZZER_DUTY_EN only) low-time duty 50/25/12.5/6.25 %
//   buzzer      : buzzer drive, 1 = off / idle level
//   busy        : high while a note or its gap is in progress
//   done        : one-clock pulse after note + gap
// Optional feature macro: BUZZER_DUTY_EN (adds duty_sel volume control).
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int CLK_FRE = 50,
  parameter int GAP_MS  = 10,
  parameter int DUR_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [PERIOD_W-1:0] cycle,
  input  logic [DUR_W-1:0]    dur_ms,
`ifdef BUZZER_DUTY_EN
  input  logic [1:0]          duty_sel,
`endif
  output logic                buzzer,
  output logic                busy,
  output logic                done
);

  // ms counter must hold both the longest note and the gap length
  localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  state_t               state, state_nxt;
  logic [PERIOD_W-1:0]  cycle_l, pcnt, half;
  logic [DUR_W-1:0]     dur_l;
  logic [CNT_W-1:0]     ms_cnt;
  logic [CNT_W:0]       ms_nxt;
  logic                 tick, accept, play_end, gap_end, tone;
`ifdef BUZZER_DUTY_EN
  logic [1:0]           duty_l;
`endif

  ms_tick_gen #(.CLK_FRE(CLK_FRE)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept | play_end),
    .en    (busy),
    .tick  (tick)
  );

  assign accept = note_valid && note_ready;

  // one bit wider than the counter so dur_ms = 2^DUR_W-1 compares without wrap
  assign ms_nxt   = {1'b0, ms_cnt} + (CNT_W + 1)'(1);
  assign play_end = (state == PLAY) && tick && (ms_nxt == (CNT_W + 1)'(dur_l));
  assign gap_end  = (state == GAP)  && tick && (ms_nxt == (CNT_W + 1)'(GAP_MS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    note_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        note_ready = 1'b1;
        done       = (state == DONE);
        if (note_valid) begin
          if (dur_ms != '0)     state_nxt = PLAY;
          else if (GAP_MS != 0) state_nxt = GAP;
          else                  state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      PLAY: begin
        busy = 1'b1;
        if (play_end) state_nxt = (GAP_MS != 0) ? GAP : DONE;
      end
      GAP: begin
        busy = 1'b1;
        if (gap_end) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tone = (cycle_l > PERIOD_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_l <= '0;
      dur_l   <= '0;
      ms_cnt  <= '0;
      pcnt    <= '0;
`ifdef BUZZER_DUTY_EN
      duty_l  <= '0;
`endif
    end else if (accept) begin
      cycle_l <= cycle;
      dur_l   <= dur_ms;
      ms_cnt  <= '0;
      pcnt    <= '0;
`ifdef BUZZER_DUTY_EN
      duty_l  <= duty_sel;
`endif
    end else if (play_end) begin
      ms_cnt <= '0;
      pcnt   <= '0;
    end else begin
      if (tick) ms_cnt <= ms_nxt[CNT_W-1:0];
      if ((state == PLAY) && tone)
        pcnt <= (pcnt == cycle_l - PERIOD_W'(1)) ? '0 : pcnt + PERIOD_W'(1);
    end
  end

  // low phase length; the remainder of an odd period lands in the high phase
`ifdef BUZZER_DUTY_EN
  assign half = cycle_l >> ({1'b0, duty_l} + 3'd1);
`else
  assign half = cycle_l >> 1;
`endif

  assign buzzer = !((state == PLAY) && tone && (pcnt < half));

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// tb_buzzer_tone_gen: self-checking bench for buzzer_tone_gen with CLK_FRE=1,
// GAP_MS=2 (1000 clocks per ms). A timeline model predicts every output from
// the clocks elapsed since acceptance and is compared on every falling edge;
// directed notes add hand-computed totals (low clocks, busy clocks, done time).
module tb_buzzer_tone_gen;

  localparam int T   = 1000;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        note_valid = 1'b0;
  logic [19:0] cycle = '0;
  logic [15:0] dur_ms = '0;
  logic        note_ready, buzzer, busy, done;

  int ntests = 0, nfail = 0, nprint = 0;
  int cyc_n = 0;
  int low_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;

  buzzer_tone_gen #(.CLK_FRE(1), .GAP_MS(GAP), .DUR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .cycle      (cycle),
    .dur_ms     (dur_ms),
    .buzzer     (buzzer),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  // Timeline model: m_k = clocks since the acceptance edge of the current note.
  bit m_act = 1'b0;
  int m_k = 0, m_cyc = 0, m_dur = 0, m_end = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_k   = 0;
    end else if ((!m_act || m_k == m_end) && note_valid) begin
      m_act = 1'b1;
      m_k   = 0;
      m_cyc = int'(cycle);
      m_dur = int'(dur_ms);
      m_end = (m_dur + GAP) * T;
    end else if (m_act) begin
      m_k++;
      if (m_k > m_end) m_act = 1'b0;
    end
  end

  // Per-cycle comparison plus activity monitors
  always @(negedge clk) begin
    logic e_buz, e_busy, e_done, e_rdy;
    e_busy = m_act && (m_k < m_end);
    e_done = m_act && (m_k == m_end);
    e_rdy  = !m_act || (m_k == m_end);
    e_buz  = !(m_act && (m_k < m_dur * T) && (m_cyc >= 2) && ((m_k % m_cyc) < (m_cyc / 2)));
    ntests++;
    if (buzzer !== e_buz || busy !== e_busy || done !== e_done || note_ready !== e_rdy) begin
      nfail++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL cycle_cmp t=%0d got/exp buzzer=%b/%b busy=%b/%b done=%b/%b ready=%b/%b",
                 cyc_n, buzzer, e_buz, busy, e_busy, done, e_done, note_ready, e_rdy);
      end
    end
    if (buzzer == 1'b0) low_cnt++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic play_note(input int c, input int d, output int acc);
    @(posedge clk); #2;
    low_cnt = 0; busy_cnt = 0; done_cnt = 0;
    note_valid = 1'b1;
    cycle      = 20'(c);
    dur_ms     = 16'(d);
    @(posedge clk); #1;
    acc = cyc_n;
    #1 note_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      ntests++;
      nfail++;
      $display("FAIL %s: no done pulse within 20000 clocks", nm);
    end
  endtask

  initial begin
    #2_000_000;
    nfail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_buzzer", buzzer, 1);
    check("rst_ready", note_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rel_buzzer", buzzer, 1);
    check("rel_ready", note_ready, 1);
    check("rel_busy", busy, 0);

    // tone note: 30 periods of 50 low / 50 high, then 2 ms gap
    play_note(100, 3, acc);
    wait_done("tone");
    @(posedge clk); #1;
    check("tone_done_lat", done_cyc - acc, 5000);
    check("tone_low", low_cnt, 1500);
    check("tone_busy", busy_cnt, 5000);
    repeat (3) @(posedge clk);
    check("tone_done_cnt", done_cnt, 1);

    // rest note
    play_note(0, 2, acc);
    wait_done("rest");
    @(posedge clk); #1;
    check("rest_done_lat", done_cyc - acc, 4000);
    check("rest_low", low_cnt, 0);
    check("rest_busy", busy_cnt, 4000);

    // zero duration: straight to the gap
    play_note(100, 0, acc);
    wait_done("zero");
    @(posedge clk); #1;
    check("zero_done_lat", done_cyc - acc, 2000);
    check("zero_low", low_cnt, 0);
    check("zero_busy", busy_cnt, 2000);

    // odd period: 3 low / 4 high, 1000 = 142*7 + 6 -> 142*3 + 3 low clocks
    play_note(7, 1, acc);
    wait_done("odd");
    @(posedge clk); #1;
    check("odd_low", low_cnt, 429);
    check("odd_done_lat", done_cyc - acc, 3000);

    // handshake: valid held while busy with changing inputs, next note in DONE
    @(posedge clk); #2;
    low_cnt = 0; busy_cnt = 0; done_cnt = 0;
    note_valid = 1'b1;
    cycle = 20'd100;
    dur_ms = 16'd1;
    @(posedge clk); #1;
    acc = cyc_n;
    for (int i = 1; i <= 2995; i++) begin
      @(posedge clk); #2;
      cycle  = 20'(3 + (i % 97));
      dur_ms = 16'(i % 5);
      if (i == 1000) check("hs_ready_busy", note_ready, 0);
    end
    cycle  = 20'd30;
    dur_ms = 16'd1;
    wait_done("hs_a");
    @(posedge clk); #1;
    acc2 = cyc_n;
    #1 note_valid = 1'b0;
    check("hs_b_accept", acc2 - acc, 3001);
    #2;
    check("hs_b_first_low", buzzer, 0);
    wait_done("hs_b");
    @(posedge clk); #1;
    check("hs_b_done_lat", done_cyc - acc2, 3000);
    // note A: 10 periods * 50 low; note B (period 30): 33*15 + 10 low
    check("hs_low", low_cnt, 1005);
    check("hs_done_cnt", done_cnt, 2);

    // abort with reset in the middle of PLAY
    play_note(100, 3, acc);
    repeat (1500) @(posedge clk);
    #1;
    check("abort_pre_low", buzzer, 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_buzzer", buzzer, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", note_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    #1 rst_n = 1'b1;
    play_note(7, 1, acc);
    wait_done("after_abort");
    @(posedge clk); #1;
    check("after_abort_low", low_cnt, 429);
    check("after_abort_lat", done_cyc - acc, 3000);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
